ex_mem_stage_reg: RTL

- EX/MEM pipeline register of the 5-stage MIPS core, directly downstream of the execute-stage ALU.
- Captures the ALU result and flags (zero/lt/gt), the store data and the MEM/WB control bits.
- Resolves conditional branches from the ALU flags in EX and presents a registered taken/target pair to the fetch stage.
- Supports pipeline stall (hold) and flush (bubble insertion).

---
 rtl/ex_mem_stage_reg.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX/MEM pipeline register of the 5-stage MIPS core.
//
// Captures the ALU result, store data, destination register and MEM/WB
// control bits from the execute stage, and resolves conditional branches
// from the ALU flags so fetch sees a registered taken/target pair.
// Update priority on each rising clock edge: rst > flush > stall > load.
//
// Optional build macro: EXMEM_OVF_TRAP_EN
//   defined   - out_ovf reports signed ADD/SUB overflow, and the faulting
//               instruction has out_reg_write/out_mem_write suppressed.
//   undefined - out_ovf is always 0; results commit with wrap-around.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid            EX stage holds a real instruction
//   stall               hold every register this cycle
//   flush               replace the stage contents with a bubble
//   alu_result          ALU result (DW)
//   alu_zero/lt/gt      ALU zero, signed less-than, signed greater-than
//   aluop               ALU operation code (0000 ADD, 0001 SUB)
//   src_a_sign/b_sign   sign bits of the two ALU operands
//   store_data          rt value for SW (DW)
//   rd                  destination register (RW)
//   reg_write, mem_read, mem_write, mem_to_reg   MEM/WB control
//   branch_type         000 none, 001 BEQ, 010 BNE, 011 BLT,
//                       100 BGT, 101 BLE, 110 BGE, 111 JUMP
//   branch_target       computed target address (DW)
//   out_*               registered stage contents
//   branch_taken        registered branch decision
//   branch_target_q     registered branch target
//   out_ovf             registered signed-overflow flag

module ex_mem_stage_reg #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    input  logic          alu_lt,
    input  logic          alu_gt,
    input  logic [3:0]    aluop,
    input  logic          src_a_sign,
    input  logic          src_b_sign,
    input  logic [DW-1:0] store_data,
    input  logic [RW-1:0] rd,
    input  logic          reg_write,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          mem_to_reg,
    input  logic [2:0]    branch_type,
    input  logic [DW-1:0] branch_target,
    output logic          out_valid,
    output logic [DW-1:0] out_alu_result,
    output logic [DW-1:0] out_store_data,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write,
    output logic          out_mem_read,
    output logic          out_mem_write,
    output logic          out_mem_to_reg,
    output logic          branch_taken,
    output logic [DW-1:0] branch_target_q,
    output logic          out_ovf
);

    localparam logic [3:0] ALUOP_ADD = 4'b0000;
    localparam logic [3:0] ALUOP_SUB = 4'b0001;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGT  = 3'b100;
    localparam logic [2:0] BR_BLE  = 3'b101;
    localparam logic [2:0] BR_BGE  = 3'b110;
    localparam logic [2:0] BR_JUMP = 3'b111;

    // Complete stage payload, held as one register so flush/stall/reset act uniformly
    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          taken;
        logic          ovf;
        logic [DW-1:0] result;
        logic [DW-1:0] store_data;
        logic [RW-1:0] rd;
        logic [DW-1:0] target;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;

    logic br_cond_c;
    logic ovf_c;
    logic trap_c;
    logic res_sign_c;

    assign res_sign_c = alu_result[DW-1];

    // Branch condition from the current ALU flags
    always_comb begin
        br_cond_c = 1'b0;
        case (branch_type)
            BR_NONE: br_cond_c = 1'b0;
            BR_BEQ:  br_cond_c = alu_zero;
            BR_BNE:  br_cond_c = ~alu_zero;
            BR_BLT:  br_cond_c = alu_lt;
            BR_BGT:  br_cond_c = alu_gt;
            BR_BLE:  br_cond_c = ~alu_gt;
            BR_BGE:  br_cond_c = ~alu_lt;
            BR_JUMP: br_cond_c = 1'b1;
            default: br_cond_c = 1'b0;
        endcase
    end

    // Signed overflow from operand and result sign bits; only ADD and SUB can overflow
    always_comb begin
        ovf_c = 1'b0;
        case (aluop)
            ALUOP_ADD: ovf_c = (src_a_sign == src_b_sign) && (res_sign_c != src_a_sign);
            ALUOP_SUB: ovf_c = (src_a_sign != src_b_sign) && (res_sign_c != src_a_sign);
            default:   ovf_c = 1'b0;
        endcase
    end

`ifdef EXMEM_OVF_TRAP_EN
    assign trap_c = ovf_c;
`else
    // Overflow is not reported in this build; results wrap as ADDU/SUBU
    logic unused_ovf;
    assign trap_c     = 1'b0;
    assign unused_ovf = ovf_c;
`endif

    // Next stage contents: flush clears, stall holds, otherwise load
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (!stall) begin
            // Data fields are captured even for a bubble; only controls are gated
            stage_d.result     = alu_result;
            stage_d.store_data = store_data;
            stage_d.rd         = rd;
            stage_d.target     = branch_target;
            stage_d.valid      = in_valid;
            // $zero is never written
            stage_d.reg_write  = in_valid & reg_write & (rd != '0) & ~trap_c;
            stage_d.mem_read   = in_valid & mem_read;
            stage_d.mem_write  = in_valid & mem_write & ~trap_c;
            stage_d.mem_to_reg = in_valid & mem_to_reg;
            stage_d.taken      = in_valid & br_cond_c;
            stage_d.ovf        = in_valid & trap_c;
        end
    end

    // Stage register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_valid       = stage_q.valid;
    assign out_alu_result  = stage_q.result;
    assign out_store_data  = stage_q.store_data;
    assign out_rd          = stage_q.rd;
    assign out_reg_write   = stage_q.reg_write;
    assign out_mem_read    = stage_q.mem_read;
    assign out_mem_write   = stage_q.mem_write;
    assign out_mem_to_reg  = stage_q.mem_to_reg;
    assign branch_taken    = stage_q.taken;
    assign branch_target_q = stage_q.target;
    assign out_ovf         = stage_q.ovf;

endmodule
